// File: rtl/udl_counter_if.sv
// udl_counter_if: control and status bundle for one udl_counter stage.
// The master side (the user or the bench) drives the count controls. The
// slave side (the counter) returns the count, terminal count and overflow.
interface udl_counter_if #(
    parameter int Width = 4
);
    logic             CE;
    logic             UP;
    logic             LOAD;
    logic [Width-1:0] D;
    logic             CLR_OVF;
    logic [Width-1:0] Q;
    logic             TC;
    logic             OVF;

    modport master (
        output CE, UP, LOAD, D, CLR_OVF,
        input  Q, TC, OVF
    );

    modport slave (
        input  CE, UP, LOAD, D, CLR_OVF,
        output Q, TC, OVF
    );
endinterface

// File: rtl/udl_counter.sv
// udl_counter: up/down counter with synchronous load, programmable terminal
// value MaxCnt (modulus MaxCnt+1), wrap or saturate at the bounds, a
// combinational cascade terminal count and a sticky overflow flag.
// Per-cycle priority is SRST > LOAD > CE; with none of them asserted, Q holds.
// Optional build macro UDL_COUNTER_TMR_EN: Q/OVF are held in three register
// copies behind a bitwise majority voter. Every copy reloads from the voted
// next state each clock, so a single upset copy is scrubbed within one cycle.
module udl_counter #(
    parameter int Width  = 4,
    parameter int MaxCnt = 2**Width - 1,
    parameter bit Sat    = 1'b0
) (
    input  logic         CLK,
    input  logic         SRST,
    udl_counter_if.slave bus
);
    localparam logic [Width-1:0] MAX_VAL  = Width'(MaxCnt);
    localparam logic [Width-1:0] ZERO_VAL = '0;

    logic [Width-1:0] q_d;
    logic             ovf_d;
    logic             at_top;
    logic             at_bot;
    logic             bound_step;

`ifdef UDL_COUNTER_TMR_EN
    (* keep = "true", preserve = "true" *) logic [Width-1:0] q0_q;
    (* keep = "true", preserve = "true" *) logic [Width-1:0] q1_q;
    (* keep = "true", preserve = "true" *) logic [Width-1:0] q2_q;
    (* keep = "true", preserve = "true" *) logic             ovf0_q;
    (* keep = "true", preserve = "true" *) logic             ovf1_q;
    (* keep = "true", preserve = "true" *) logic             ovf2_q;
    (* keep = "true", preserve = "true" *) logic [Width-1:0] q_q;
    (* keep = "true", preserve = "true" *) logic             ovf_q;

    // Bitwise majority vote; all logic downstream sees only the voted state.
    assign q_q   = (q0_q & q1_q) | (q0_q & q2_q) | (q1_q & q2_q);
    assign ovf_q = (ovf0_q & ovf1_q) | (ovf0_q & ovf2_q) | (ovf1_q & ovf2_q);

    // All three copies reload from the voted next state every clock (scrubbing).
    always_ff @(posedge CLK) begin
        if (SRST) begin
            q0_q   <= '0;
            q1_q   <= '0;
            q2_q   <= '0;
            ovf0_q <= 1'b0;
            ovf1_q <= 1'b0;
            ovf2_q <= 1'b0;
        end else begin
            q0_q   <= q_d;
            q1_q   <= q_d;
            q2_q   <= q_d;
            ovf0_q <= ovf_d;
            ovf1_q <= ovf_d;
            ovf2_q <= ovf_d;
        end
    end
`else
    logic [Width-1:0] q_q;
    logic             ovf_q;

    // Single register set for count and sticky overflow.
    always_ff @(posedge CLK) begin
        if (SRST) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end
`endif

    // A boundary step is a CE step attempted at the bound in the current direction.
    always_comb begin
        at_top     = (q_q == MAX_VAL);
        at_bot     = (q_q == ZERO_VAL);
        bound_step = bus.CE & (bus.UP ? at_top : at_bot);
    end

    // Next-state: LOAD (clamped to MaxCnt) beats CE; the OVF set beats CLR_OVF.
    always_comb begin
        q_d   = q_q;
        ovf_d = bus.CLR_OVF ? 1'b0 : ovf_q;
        if (bus.LOAD) begin
            q_d = (bus.D > MAX_VAL) ? MAX_VAL : bus.D;
        end else if (bus.CE) begin
            if (bus.UP) begin
                if (!at_top) q_d = q_q + 1'b1;
                else         q_d = Sat ? MAX_VAL : ZERO_VAL;
            end else begin
                if (!at_bot) q_d = q_q - 1'b1;
                else         q_d = Sat ? ZERO_VAL : MAX_VAL;
            end
            if (bound_step) ovf_d = 1'b1;
        end
    end

    // Outputs: registered count and flag, combinational terminal count.
    assign bus.Q   = q_q;
    assign bus.OVF = ovf_q;
    assign bus.TC  = bound_step;
endmodule

// File: doc/udl_counter.md
# udl_counter

Parametrised up/down counter with synchronous load, programmable modulus, wrap or saturate mode, a cascadable terminal-count output and a sticky overflow flag. It is the general-purpose successor to the plain clock-enabled binary counter, used for event, timeout and address counting in the DMB control logic. Optional triple-modular redundancy with self-scrubbing registers is compiled in by macro for radiation-exposed builds.

## Interface
- `Width`, default 4: counter width in bits; minimum 2.
- `MaxCnt`, default 2**Width-1: terminal value, so the modulus is `MaxCnt`+1. Legal range is 1..2**Width-1.
- `Sat`, default 0: 0 = wrap at the bounds, 1 = saturate at the bounds.
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `SRST`  in  1  synchronous, active-high reset.
- `CE`  in  1  count enable.
- `UP`  in  1  direction: 1 = increment, 0 = decrement.
- `LOAD`  in  1  synchronous load strobe.
- `D`  in  Width  load value.
- `CLR_OVF`  in  1  clears the sticky overflow flag.
- `Q`  out  Width  registered count.
- `TC`  out  1  combinational terminal count, for cascading.
- `OVF`  out  1  registered sticky overflow/saturation flag.

## Operation
- Priority per cycle is SRST > LOAD > CE. With none of them asserted, Q holds.
- SRST: Q and OVF both go to 0.
- LOAD, independent of CE:
  - Q <= D when D <= MaxCnt.
  - Q <= MaxCnt when D > MaxCnt (clamped).
  - LOAD never sets OVF.
- CE with UP=1:
  - Q < MaxCnt: Q <= Q+1.
  - Q == MaxCnt: Q <= 0 if Sat=0; Q holds at MaxCnt if Sat=1.
- CE with UP=0:
  - Q > 0: Q <= Q-1.
  - Q == 0: Q <= MaxCnt if Sat=0; Q holds at 0 if Sat=1.
- Boundary step: a CE step attempted at the bound in the current direction (wrap or saturate) sets OVF the next edge.
- OVF behaviour:
  - Stays set until CLR_OVF or SRST.
  - If CLR_OVF and a boundary step occur in the same cycle, the set wins and OVF stays 1.
  - CLR_OVF with no boundary step clears OVF.
  - SRST overrides everything.
- TC = CE & ((UP & Q==MaxCnt) | (~UP & Q==0)).
  - Purely combinational on CE, UP and Q; it ignores LOAD and SRST.
  - Cascading: feed TC of the low stage into CE of the next stage. Both stages share UP and Sat=0.
- Q is always within 0..MaxCnt after reset. An out-of-range Q is unreachable.

## Timing
- Reset values: Q=0, OVF=0. TC=0 unless CE=1 and UP=0 (Q=0 is the down terminal).
- Latency:
  - Q updates one clock after the qualifying input is sampled.
  - OVF sets on the same edge that performs the wrap or saturation step.
  - TC has zero latency (combinational).
- SRST asserted mid-count: the next edge forces Q=0 and OVF=0, whatever LOAD, CE or CLR_OVF are doing.
- Direction change with CE high: takes effect on the same edge. There is no pipeline and no dead cycle.
- Throughput: one step per clock while CE=1.

## Configuration
- Macro: `UDL_COUNTER_TMR_EN`.
- Defined:
  - Q and OVF state is held in three register copies, combined by bitwise majority vote.
  - Outputs and next-state logic use the voted value only.
  - Every copy reloads from the voted next state on every clock, including hold cycles, so a single upset copy is scrubbed within one cycle.
  - The register copies and voted nets carry preserve/keep synthesis attributes so redundancy is not optimised away.
- Undefined: single register set, no voter.
- Cycle-level function at the ports is identical in both builds.

## Test plan
- Reset and up-count: Width=4, MaxCnt=9, Sat=0, SRST pulse then CE=UP=1 for 12 cycles -> Q: 0,1..9,0,1,2. OVF rises on the edge 9->0. TC=1 only while Q=9.
- Saturate down: Sat=1, LOAD D=2, then CE=1, UP=0 for 4 cycles -> Q: 2,1,0,0,0. OVF sets on the first held-at-0 step. TC=1 while Q=0.
- Load clamp and priority: MaxCnt=9, LOAD=1, D=13 with CE=1 -> Q=9, OVF unchanged. Next, SRST=1 with LOAD=1, D=5 -> Q=0, OVF=0.
- OVF set/clear race: Q=9, UP=1, CE=1, CLR_OVF=1 -> OVF=1. Next cycle CLR_OVF=1, CE=0 -> OVF=0.
- Cascade: two instances, Width=4, MaxCnt=9, low-stage TC driving high-stage CE, 100 up steps -> {hi,lo} reads 0,0 after wrap, with a decimal-correct sequence throughout. Repeat downward from 0,0 -> 9,9.
- With `UDL_COUNTER_TMR_EN`: force one Q copy to 5 for one cycle while counting -> Q port sequence is unaffected, and the forced copy equals the other two after the next edge.
